// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller: state encoding and
// default budget/drain constants.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4,
    TIMEOUT = 3'd5
  } run_state_t;

  localparam int RUN_MAX_CYCLES   = 10000;
  localparam int RUN_DRAIN_CYCLES = 4;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    if (n < 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/drain_timer.sv
// One-shot down counter that measures the drain interval after a halt is
// accepted; done is high for the single cycle the armed count sits at zero.
module drain_timer
  import run_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = RUN_DRAIN_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int CNT_W = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VALUE =
    CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  logic             armed;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      count <= '0;
    end else if (start) begin
      armed <= 1'b1;
      count <= LOAD_VALUE;
    end else if (armed) begin
      // Disarm once the zero count has been reported so done is a single pulse.
      if (count == '0) begin
        armed <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = armed && (count == '0);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: owns the pipeline enable, counts executed cycles against a
// budget, drains before halting and grants debug pause.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES   = RUN_MAX_CYCLES,
  parameter int DRAIN_CYCLES = RUN_DRAIN_CYCLES,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt_req,
  input  logic          pause_req,
  output logic          run,
  output logic          pause_ack,
  output logic          halt,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);
  localparam bit            HAS_DRAIN  = (DRAIN_CYCLES > 0);

  run_state_t state;
  logic       drain_start;
  logic       drain_done;

  assign drain_start = HAS_DRAIN && (state == RUN) && halt_req;

  drain_timer #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_drain_timer (
    .clk  (clk),
    .reset(reset),
    .start(drain_start),
    .done (drain_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      run       <= 1'b0;
      pause_ack <= 1'b0;
      halt      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= '0;
    end else begin
      // Count the edge itself when leaving RUN/DRAIN, so TIMEOUT lands on MAX_CYCLES.
      if ((state == RUN) || (state == DRAIN)) begin
        cycles <= cycles + 1'b1;
      end

      case (state)
        BOOT: begin
          state <= RUN;
          run   <= 1'b1;
        end

        RUN: begin
          if (halt_req) begin
            run <= 1'b0;
            if (HAS_DRAIN) begin
              state <= DRAIN;
            end else begin
              state <= HALTED;
              halt  <= 1'b1;
            end
          end else if (cycles == LAST_CYCLE) begin
            state   <= TIMEOUT;
            run     <= 1'b0;
            halt    <= 1'b1;
            timeout <= 1'b1;
          end else if (pause_req) begin
            state     <= PAUSE;
            run       <= 1'b0;
            pause_ack <= 1'b1;
          end
        end

        PAUSE: begin
          if (!pause_req) begin
            state     <= RUN;
            run       <= 1'b1;
            pause_ack <= 1'b0;
          end
        end

        DRAIN: begin
          if (drain_done) begin
            state <= HALTED;
            halt  <= 1'b1;
          end
        end

        // HALTED and TIMEOUT hold until reset.
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sequences the simulation clock's halt and cycle-limit functions for the processor. It owns the global pipeline enable, and counts executed cycles against a fixed budget. On a committed halt it drains in-flight work for a fixed number of cycles before raising `halt` to the clock module. It also grants a pause handshake to a debug requester. It sits between the writeback stage, the debug port and `clock`.

## Interface
- `MAX_CYCLES`, 10000: cycle budget; reaching it forces TIMEOUT.
- `DRAIN_CYCLES`, 4: cycles between halt acceptance and `halt` assertion (0 legal).
- `CW`, 16: cycle counter width; `MAX_CYCLES` < 2^CW.

- `clk` in 1: sole clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high; forces BOOT immediately.
- `halt_req` in 1: halt instruction committed this cycle; single-cycle pulse.
- `pause_req` in 1: debug pause request; level, held until released.
- `run` out 1: global pipeline enable.
- `pause_ack` out 1: pipeline frozen for debug.
- `halt` out 1: stop simulation; drives `clock.halt`.
- `timeout` out 1: budget exhausted without halt.
- `cycles` out CW: cycles spent in RUN or DRAIN.

## Operation
- Moore machine: all outputs decode from the state register and `cycles` register. No input-to-output combinational path.
- States: BOOT, RUN, PAUSE, DRAIN, HALTED, TIMEOUT.
- Reset values: state BOOT, `run`=0, `pause_ack`=0, `halt`=0, `timeout`=0, `cycles`=0, drain count 0.
- BOOT -> RUN unconditionally on the first edge after `reset` deasserts.
- RUN (`run`=1). Evaluated in priority order each edge:
  - `halt_req` -> DRAIN if `DRAIN_CYCLES`>0, else HALTED.
  - else if `cycles`==`MAX_CYCLES`-1 -> TIMEOUT.
  - else if `pause_req` -> PAUSE.
- PAUSE (`run`=0, `pause_ack`=1):
  - `pause_req`=0 -> RUN.
  - `cycles` frozen.
  - `halt_req` is ignored; it cannot legally occur here and the bench asserts this.
- DRAIN (`run`=0):
  - Drain counter loads `DRAIN_CYCLES`-1 on entry and decrements each edge.
  - At 0 -> HALTED.
  - `pause_req` and the budget are ignored in DRAIN.
- HALTED (`halt`=1) and TIMEOUT (`halt`=1, `timeout`=1) are terminal until `reset`.
- `cycles`:
  - +1 on every edge where state is RUN or DRAIN.
  - Holds in BOOT, PAUSE, HALTED and TIMEOUT.
  - Never wraps: TIMEOUT is entered at `MAX_CYCLES`-1, the counter increments once to `MAX_CYCLES`, then freezes.
- `reset` asserted in any state, including mid-DRAIN or mid-PAUSE: BOOT asynchronously, all outputs return to reset values without waiting for a clock edge.

## Timing
- `halt_req` sampled high at edge N: `run`=0 after edge N; `halt`=1 after edge N+`DRAIN_CYCLES`.
- `pause_req` high at edge N in RUN: `run`=0 and `pause_ack`=1 after edge N. Release at edge M: `run`=1 after edge M.
- The budget is exhausted when `cycles`==`MAX_CYCLES`-1 at edge N and there is no `halt_req`: `timeout`=`halt`=1 after edge N.
- The first `run`=1 cycle is one cycle after reset release (the BOOT cycle).
- `clock` samples `halt` on its own posedge and therefore finishes one edge after `halt` rises.

## Structure
- Package `run_ctrl_pkg`: state enum `run_state_t` with the six states and fixed 3-bit encoding (BOOT=0), plus default constants `RUN_MAX_CYCLES`=10000 and `RUN_DRAIN_CYCLES`=4.
- Sub-module `drain_timer` (parameter `DRAIN_CYCLES`):
  - inputs `clk`, `reset`, `start`; output `done`.
  - `done` is combinational when the count is 0 and the timer is armed.
  - `run_ctrl` instantiates it once.
- The cycle counter and the state machine stay in `run_ctrl`.

## Test plan
- Reset release, idle 20 cycles: `run`=1 from the 2nd edge; `cycles`=19 after 20 edges; `halt`=0.
- `halt_req` pulse at `cycles`=100, `DRAIN_CYCLES`=4:
  - `run`=0 next cycle; `halt`=1 exactly 4 edges after the pulse edge.
  - `cycles`=105 final; `timeout`=0.
- `DRAIN_CYCLES`=0 and `halt_req` at `cycles`=7: `halt`=1 after the same edge; `cycles`=8.
- `pause_req` held 50 cycles at `cycles`=30: `pause_ack`=1 and `run`=0 throughout; `cycles` stays 31; RUN resumes one edge after release.
- No halt with `MAX_CYCLES`=64: `timeout`=`halt`=1 after the edge where `cycles`=63; `cycles` holds 64.
- Simultaneous `halt_req` and `pause_req` in RUN: DRAIN, and `pause_ack` stays 0.
- `reset` asserted mid-DRAIN between edges: all outputs are 0 immediately; BOOT -> RUN after release.
